xadc_drp_master: RTL and testbench

- Dynamic-reconfiguration-port (DRP) initiator that drives the XADC wizard's DRP from fabric.
- Converts each end-of-conversion pulse into a properly handshaken channel read, and arbitrates host-requested register writes (e.g. sequencer/averaging configuration).
- Delivers a 12-bit sample with a valid strobe to the gripper pressure/force control loop, plus sticky error status.

---
 rtl/xadc_pkg.sv | 27 ++
 rtl/drp_avg4.sv | 42 ++++
 rtl/xadc_drp_master.sv | 153 +++++++++++++++
 tb/tb_xadc_drp_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP initiator: FSM states, DRP
// register addresses, bus widths and the DRP-word-to-sample helper.
package xadc_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;
    localparam int SAMPLE_W   = 12;

    localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX6 = 7'h16;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CFG0  = 7'h40;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CFG1  = 7'h41;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CFG2  = 7'h42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_WR_WAIT
    } drp_state_t;

    // The XADC left-justifies its 12-bit result in the 16-bit status register.
    function automatic logic [SAMPLE_W-1:0] drp_to_sample(input logic [DRP_DATA_W-1:0] word);
        return word[DRP_DATA_W-1:DRP_DATA_W-SAMPLE_W];
    endfunction

endpackage

// File: rtl/drp_avg4.sv
// Four-tap running-mean buffer for XADC samples; only built when
// XADC_DRP_AVG4_EN is defined. Outputs describe the state after a pending push.
`ifdef XADC_DRP_AVG4_EN
module drp_avg4
    import xadc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [SAMPLE_W-1:0] raw,
    output logic [SAMPLE_W-1:0] next_mean,
    output logic                next_full
);

    logic [3:0][SAMPLE_W-1:0] taps;
    logic [SAMPLE_W+1:0]      sum;
    logic [SAMPLE_W+1:0]      next_sum;
    logic [2:0]               fill;

    // Taps start at zero, so subtracting the oldest entry is valid even while filling.
    always_comb begin
        next_sum  = sum + {2'b00, raw} - {2'b00, taps[3]};
        next_mean = next_sum[SAMPLE_W+1:2];
        next_full = (fill >= 3'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taps <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (push) begin
            taps <= {taps[2:0], raw};
            sum  <= next_sum;
            if (fill != 3'd4) begin
                fill <= fill + 3'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/xadc_drp_master.sv
// DRP initiator for the XADC wizard: EOC-triggered channel reads, host register
// writes, timeout and overrun status. Define XADC_DRP_AVG4_EN for 4-sample averaging.
module xadc_drp_master
    import xadc_pkg::*;
#(
    parameter logic [DRP_ADDR_W-1:0] CH_ADDR     = ADDR_VAUX6,
    parameter int unsigned           TIMEOUT_CYC = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  eoc_in,
    output logic [DRP_ADDR_W-1:0] drp_daddr,
    output logic                  drp_den,
    output logic                  drp_dwe,
    output logic [DRP_DATA_W-1:0] drp_di,
    input  logic [DRP_DATA_W-1:0] drp_do,
    input  logic                  drp_drdy,
    input  logic                  wr_req,
    input  logic [DRP_ADDR_W-1:0] wr_addr,
    input  logic [DRP_DATA_W-1:0] wr_data,
    output logic                  wr_ack,
    output logic [SAMPLE_W-1:0]   sample,
    output logic                  sample_valid,
    output logic                  busy,
    input  logic                  clr_err,
    output logic                  timeout_err,
    output logic                  overrun_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    drp_state_t          state;
    logic                pending;
    logic [7:0]          tmo_cnt;
    logic                tmo_hit;
    logic                tmo_event;
    logic [SAMPLE_W-1:0] raw_sample;
    logic [SAMPLE_W-1:0] new_sample;
    logic                new_valid;

    assign raw_sample = drp_to_sample(drp_do);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign tmo_event  = ((state == ST_RD_WAIT) || (state == ST_WR_WAIT)) && !drp_drdy && tmo_hit;
    assign busy       = (state != ST_IDLE);

`ifdef XADC_DRP_AVG4_EN
    logic avg_push;

    assign avg_push = (state == ST_RD_WAIT) && drp_drdy;

    drp_avg4 u_avg4 (
        .clk       (CLK),
        .reset     (RESET),
        .push      (avg_push),
        .raw       (raw_sample),
        .next_mean (new_sample),
        .next_full (new_valid)
    );
`else
    assign new_sample = raw_sample;
    assign new_valid  = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            pending      <= 1'b0;
            tmo_cnt      <= '0;
            drp_daddr    <= '0;
            drp_den      <= 1'b0;
            drp_dwe      <= 1'b0;
            drp_di       <= '0;
            wr_ack       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            drp_den      <= 1'b0;
            drp_dwe      <= 1'b0;
            wr_ack       <= 1'b0;
            sample_valid <= 1'b0;

            if (eoc_in) begin
                pending <= 1'b1;
            end else if (state == ST_RD_ISSUE) begin
                pending <= 1'b0;
            end

            if (eoc_in && pending && (state != ST_IDLE)) begin
                overrun_err <= 1'b1;
            end else if (clr_err) begin
                overrun_err <= 1'b0;
            end

            if (tmo_event) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pending || eoc_in) begin
                        state     <= ST_RD_ISSUE;
                        drp_den   <= 1'b1;
                        drp_daddr <= CH_ADDR;
                    // A host still holding wr_req during its own ack cycle is not a new request.
                    end else if (wr_req && !wr_ack) begin
                        state     <= ST_WR_ISSUE;
                        drp_den   <= 1'b1;
                        drp_dwe   <= 1'b1;
                        drp_daddr <= wr_addr;
                        drp_di    <= wr_data;
                    end
                end
                ST_RD_ISSUE: begin
                    state   <= ST_RD_WAIT;
                    tmo_cnt <= '0;
                end
                ST_RD_WAIT: begin
                    if (drp_drdy) begin
                        if (new_valid) begin
                            sample       <= new_sample;
                            sample_valid <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (tmo_hit) begin
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_WR_ISSUE: begin
                    state   <= ST_WR_WAIT;
                    tmo_cnt <= '0;
                end
                ST_WR_WAIT: begin
                    if (drp_drdy || tmo_hit) begin
                        wr_ack <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_master.sv
// Self-checking bench for xadc_drp_master: DRP slave responder, sample/write
// scoreboard, vector table and hand sequences. Honours XADC_DRP_AVG4_EN.
module tb_xadc_drp_master;
    import xadc_pkg::*;

    localparam int TMO = 64;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        eoc_in = 1'b0;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        wr_req = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic [11:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        clr_err = 1'b0;
    logic        timeout_err;
    logic        overrun_err;

    xadc_drp_master #(.CH_ADDR(7'h16), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .eoc_in(eoc_in),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .sample(sample), .sample_valid(sample_valid), .busy(busy),
        .clr_err(clr_err), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    int          rsp_delay = 3;
    logic [15:0] rsp_data = '0;
    int          countdown = -1;
    bit          out_is_read = 1'b0;
    bit          out_accept = 1'b0;
    int          valid_count = 0;
    int          ack_count = 0;
    int          last_drdy_cycle = 0;
    int          last_valid_cycle = 0;
    bit          txn_log[$];
    logic [6:0]  exp_wr_addr_q[$];
    logic [15:0] exp_wr_q[$];
    logic [11:0] exp_sample_q[$];
    logic [11:0] model_last = '0;
`ifdef XADC_DRP_AVG4_EN
    int          model_reads = 0;
    logic [11:0] hist[$];
`endif

    typedef struct {
        logic [15:0] data;
        int          delay;
        bit          exp_timeout;
    } vec_t;

    vec_t        vecs[8];
    logic [6:0]  cfg_addrs[3];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: each accepted read yields the raw value, or the mean of the last four once four reads exist.
    function automatic void modelAccept(input logic [15:0] word);
        logic [11:0] raw;
        raw = word[15:4];
`ifdef XADC_DRP_AVG4_EN
        begin
            int s;
            hist.push_back(raw);
            if (hist.size() > 4) void'(hist.pop_front());
            model_reads++;
            if (model_reads >= 4) begin
                s = 0;
                foreach (hist[i]) s += int'(hist[i]);
                model_last = 12'(s / 4);
                exp_sample_q.push_back(model_last);
            end
        end
`else
        model_last = raw;
        exp_sample_q.push_back(raw);
`endif
    endfunction

    function automatic void modelReset();
        exp_sample_q.delete();
        exp_wr_q.delete();
        exp_wr_addr_q.delete();
        out_accept = 1'b0;
`ifdef XADC_DRP_AVG4_EN
        hist.delete();
        model_reads = 0;
`endif
    endfunction

    // DRP slave responder and output monitor, sampling 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cycle++;
            drp_drdy = 1'b0;
            drp_do   = 16'($urandom);
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = rsp_data;
                    last_drdy_cycle = cycle;
                    if (out_is_read && out_accept) modelAccept(rsp_data);
                    countdown = -1;
                end
            end
            if (drp_den) begin
                checkOutput("one_outstanding", 32'(countdown >= 0), 32'd0);
                txn_log.push_back(drp_dwe);
                if (!drp_dwe) begin
                    checkOutput("rd_addr", 32'(drp_daddr), 32'h16);
                end else if (exp_wr_q.size() > 0) begin
                    checkOutput("wr_addr", 32'(drp_daddr), 32'(exp_wr_addr_q.pop_front()));
                    checkOutput("wr_data", 32'(drp_di), 32'(exp_wr_q.pop_front()));
                end else begin
                    checkOutput("write_expected", 32'(exp_wr_q.size()), 32'd1);
                end
                out_is_read = !drp_dwe;
                out_accept  = (rsp_delay >= 1) && (rsp_delay <= TMO);
                countdown   = (rsp_delay >= 1) ? rsp_delay : -1;
            end
            if (sample_valid) begin
                valid_count++;
                last_valid_cycle = cycle;
                if (exp_sample_q.size() > 0) checkOutput("sample_value", 32'(sample), 32'(exp_sample_q.pop_front()));
                else checkOutput("valid_expected", 32'(exp_sample_q.size()), 32'd1);
            end
            if (wr_ack) ack_count++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic pulseEoc();
        eoc_in = 1'b1;
        tick(1);
        eoc_in = 1'b0;
    endtask

    task automatic clearErrors();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    task automatic waitQuiet(input string tag, input int budget);
        int quiet = 0;
        for (int i = 0; i < budget && quiet < 3; i++) begin
            tick(1);
            if (!busy && countdown < 0 && !eoc_in) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) checkOutput({tag, "_idle_bound"}, 32'(quiet), 32'd3);
    endtask

    task automatic waitAck(input string tag, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick(1);
            if (wr_ack) got = 1'b1;
        end
        wr_req = 1'b0;
        if (!got) checkOutput({tag, "_ack_bound"}, 32'(got), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_den"}, 32'(drp_den), 32'd0);
        checkOutput({tag, "_dwe"}, 32'(drp_dwe), 32'd0);
        checkOutput({tag, "_daddr"}, 32'(drp_daddr), 32'd0);
        checkOutput({tag, "_di"}, 32'(drp_di), 32'd0);
        checkOutput({tag, "_wr_ack"}, 32'(wr_ack), 32'd0);
        checkOutput({tag, "_sample"}, 32'(sample), 32'd0);
        checkOutput({tag, "_valid"}, 32'(sample_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_tmo"}, 32'(timeout_err), 32'd0);
        checkOutput({tag, "_ovr"}, 32'(overrun_err), 32'd0);
    endtask

    // One EOC-triggered read against the responder configured from a table entry.
    task automatic applyStimulus(input vec_t v, input int idx);
        int v0;
        rsp_delay = v.delay;
        rsp_data  = v.data;
        clearErrors();
        v0 = valid_count;
        pulseEoc();
        waitQuiet($sformatf("vec%0d", idx), 300);
        checkOutput($sformatf("vec%0d_tmo", idx), 32'(timeout_err), 32'(v.exp_timeout));
        checkOutput($sformatf("vec%0d_strobes", idx), 32'(valid_count - v0), v.exp_timeout ? 32'd0 : 32'd1);
`ifndef XADC_DRP_AVG4_EN
        if (!v.exp_timeout) checkOutput($sformatf("vec%0d_sample", idx), 32'(sample), 32'(v.data[15:4]));
`endif
    endtask

    initial begin
        int v0;
        int a0;
        bit do_wr;

        cfg_addrs[0] = ADDR_CFG0;
        cfg_addrs[1] = ADDR_CFG1;
        cfg_addrs[2] = ADDR_CFG2;
        vecs[0] = '{16'h1230, 1, 1'b0};
        vecs[1] = '{16'hFFF0, 64, 1'b0};
        vecs[2] = '{16'h7770, 65, 1'b1};
        vecs[3] = '{16'h4440, -1, 1'b1};
        vecs[4] = '{16'($urandom), 2, 1'b0};
        vecs[5] = '{16'($urandom), 63, 1'b0};
        vecs[6] = '{16'h000F, 5, 1'b0};
        vecs[7] = '{16'hFFFF, 4, 1'b0};

        tick(3);
        checkResetState("reset");
        RESET = 1'b0;
        tick(2);

`ifdef XADC_DRP_AVG4_EN
        rsp_delay = 3;
        v0 = valid_count;
        for (int k = 1; k <= 5; k++) begin
            rsp_data = {12'(k * 100), 4'h0};
            pulseEoc();
            waitQuiet("avg", 100);
            if (k == 3) checkOutput("avg_no_strobe_first3", 32'(valid_count - v0), 32'd0);
            if (k == 4) checkOutput("avg_first_sample", 32'(sample), 32'd250);
            if (k == 5) checkOutput("avg_second_sample", 32'(sample), 32'd350);
        end
        checkOutput("avg_strobes", 32'(valid_count - v0), 32'd2);
`endif

        rsp_delay = 3;
        rsp_data  = 16'hABC0;
        v0 = valid_count;
        eoc_in = 1'b1;
        tick(1);
        eoc_in = 1'b0;
        checkOutput("basic_den", 32'(drp_den), 32'd1);
        checkOutput("basic_dwe", 32'(drp_dwe), 32'd0);
        checkOutput("basic_daddr", 32'(drp_daddr), 32'h16);
        waitQuiet("basic", 100);
        checkOutput("basic_strobes", 32'(valid_count - v0), 32'd1);
        checkOutput("basic_latency", 32'(last_valid_cycle - last_drdy_cycle), 32'd1);
        checkOutput("basic_sample", 32'(sample), 32'(model_last));
`ifndef XADC_DRP_AVG4_EN
        checkOutput("basic_sample_raw", 32'(sample), 32'hABC);
`endif

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        rsp_delay = 3;
        clearErrors();
        txn_log.delete();
        a0 = ack_count;
        wr_addr = ADDR_CFG1;
        wr_data = 16'h2000;
        exp_wr_addr_q.push_back(ADDR_CFG1);
        exp_wr_q.push_back(16'h2000);
        wr_req = 1'b1;
        pulseEoc();
        waitAck("arb", 100);
        waitQuiet("arb", 100);
        tick(5);
        checkOutput("arb_txn_count", 32'(txn_log.size()), 32'd2);
        if (txn_log.size() >= 2) begin
            checkOutput("arb_first_is_read", 32'(txn_log[0]), 32'd0);
            checkOutput("arb_second_is_write", 32'(txn_log[1]), 32'd1);
        end
        checkOutput("arb_ack_count", 32'(ack_count - a0), 32'd1);

        rsp_delay = 12;
        rsp_data  = 16'h3210;
        txn_log.delete();
        v0 = valid_count;
        pulseEoc();
        tick(3);
        pulseEoc();
        tick(1);
        pulseEoc();
        tick(1);
        pulseEoc();
        waitQuiet("ovr", 200);
        tick(4);
        checkOutput("ovr_reads", 32'(txn_log.size()), 32'd2);
        checkOutput("ovr_strobes", 32'(valid_count - v0), 32'd2);
        checkOutput("ovr_flag_sticky", 32'(overrun_err), 32'd1);
        clearErrors();
        checkOutput("ovr_flag_cleared", 32'(overrun_err), 32'd0);

        rsp_delay = -1;
        v0 = valid_count;
        pulseEoc();
        tick(40);
        checkOutput("tmo_not_yet", 32'(timeout_err), 32'd0);
        checkOutput("tmo_still_busy", 32'(busy), 32'd1);
        tick(30);
        checkOutput("tmo_flag", 32'(timeout_err), 32'd1);
        checkOutput("tmo_idle", 32'(busy), 32'd0);
        checkOutput("tmo_no_strobe", 32'(valid_count - v0), 32'd0);
        rsp_delay = 2;
        rsp_data  = 16'h0990;
        pulseEoc();
        waitQuiet("tmo_recover", 100);
        checkOutput("tmo_recover_strobe", 32'(valid_count - v0), 32'd1);

        rsp_delay = -1;
        clearErrors();
        a0 = ack_count;
        wr_addr = ADDR_CFG0;
        wr_data = 16'($urandom);
        exp_wr_addr_q.push_back(ADDR_CFG0);
        exp_wr_q.push_back(wr_data);
        wr_req = 1'b1;
        waitAck("wr_tmo", 150);
        waitQuiet("wr_tmo", 50);
        checkOutput("wr_tmo_ack", 32'(ack_count - a0), 32'd1);
        checkOutput("wr_tmo_flag", 32'(timeout_err), 32'd1);
        clearErrors();

        for (int k = 0; k < 20; k++) begin
            rsp_delay = int'($urandom_range(1, 12));
            rsp_data  = 16'($urandom);
            v0 = valid_count;
            a0 = ack_count;
            do_wr = ($urandom_range(0, 2) == 0);
            if (do_wr) begin
                wr_addr = cfg_addrs[$urandom_range(0, 2)];
                wr_data = 16'($urandom);
                exp_wr_addr_q.push_back(wr_addr);
                exp_wr_q.push_back(wr_data);
                wr_req = 1'b1;
            end
            pulseEoc();
            if (do_wr) waitAck("rand", 200);
            waitQuiet("rand", 200);
            checkOutput("rand_strobe", 32'(valid_count - v0), 32'd1);
            if (do_wr) checkOutput("rand_ack", 32'(ack_count - a0), 32'd1);
        end

        rsp_delay = 20;
        rsp_data  = 16'h5550;
        v0 = valid_count;
        pulseEoc();
        tick(5);
        RESET = 1'b1;
        modelReset();
        tick(1);
        checkResetState("midreset");
        RESET = 1'b0;
        waitQuiet("midreset", 100);
        checkOutput("midreset_no_strobe", 32'(valid_count - v0), 32'd0);
        checkOutput("midreset_sample", 32'(sample), 32'd0);
        checkOutput("midreset_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
